// File: rtl/logic_unit_q.sv
// Registered bitwise logic unit with an optional accumulator as operand A.
// Each result, with its zero and parity flags, is queued in a DEPTH-entry output FIFO.
module logic_unit_q #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [2:0]                   in_op,
    input  logic                         in_acc,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_y,
    output logic                         out_zero,
    output logic                         out_parity,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 2;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [WIDTH-1:0] acc_r;
    logic [EW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;

    logic [WIDTH-1:0] acc_eff_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] result_s;
    logic [EW-1:0]    entry_s;
    logic [EW-1:0]    head_s;
    logic             push_s;
    logic             pop_s;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (level_r != LVL_FULL);
    assign out_valid = (level_r != {LW{1'b0}});
    assign level     = level_r;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Operand selection and bitwise operation
    always_comb begin
        acc_eff_s = {WIDTH{1'b0}};
        opa_s     = {WIDTH{1'b0}};
        result_s  = {WIDTH{1'b0}};
        if (acc_clr) begin
            acc_eff_s = {WIDTH{1'b0}};
        end else begin
            acc_eff_s = acc_r;
        end
        if (in_acc) begin
            opa_s = acc_eff_s;
        end else begin
            opa_s = in_a;
        end
        case (in_op)
            3'b000:  result_s = opa_s & in_b;
            3'b001:  result_s = opa_s | in_b;
            3'b010:  result_s = opa_s ^ in_b;
            3'b011:  result_s = ~(opa_s & in_b);
            3'b100:  result_s = ~(opa_s | in_b);
            3'b101:  result_s = ~(opa_s ^ in_b);
            3'b110:  result_s = opa_s & ~in_b;
            3'b111:  result_s = opa_s;
            default: result_s = opa_s;
        endcase
        entry_s = {result_s, (result_s == {WIDTH{1'b0}}), calc_parity(result_s)};
    end

    // Head read; an empty FIFO presents all-zero outputs
    always_comb begin
        head_s = {EW{1'b0}};
        if (out_valid) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {EW{1'b0}};
        end
    end

    assign out_y      = head_s[EW-1:2];
    assign out_zero   = head_s[1];
    assign out_parity = head_s[0];

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy and accumulator; reset discards in-flight entries
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            // an accepted accumulate op wins over a simultaneous clear
            if (push_s && in_acc) begin
                acc_r <= result_s;
            end else if (acc_clr) begin
                acc_r <= {WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_q.sv
// Directed scoreboard bench for logic_unit_q (WIDTH=4, DEPTH=2).
module tb_logic_unit_q;

    localparam int W = 4;
    localparam int D = 2;
    localparam logic [3:0] SWEEP_Y [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                           4'b0001, 4'b1001, 4'b0100, 4'b1100};
    localparam logic [7:0] SWEEP_P = 8'b0101_1011;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_parity;
    logic [1:0]   level;

    logic [W+1:0] sb [$];
    int errors = 0;
    int checks = 0;

    logic_unit_q #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_parity(out_parity),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request, wait for in_ready, and log its expected entry
    task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic acc, input logic clr,
                       input logic [3:0] ey, input logic ez, input logic ep);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; acc_clr = clr;
        for (int n = 0; n < 20; n++) begin
            if (in_ready) begin
                sb.push_back({ey, ez, ep});
                tick();
                in_valid = 1'b0;
                acc_clr  = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $error("FAIL req_timeout observed=in_ready_low expected=in_ready_high");
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    // Output monitor: every pop is compared against the scoreboard head
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!reset) begin
            check("level_bound", 32'(level > 2'd2), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_output observed=%0h expected=none", out_y);
                end else begin
                    e = sb.pop_front();
                    check("head_y", 32'(out_y), 32'(e[5:2]));
                    check("head_zero", 32'(out_zero), 32'(e[1]));
                    check("head_parity", 32'(out_parity), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = 4'b0000; in_b = 4'b0000; in_op = 3'b000;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_flags", 32'({out_zero, out_parity}), 32'd0);
        reset = 1'b0;

        // Op sweep, A=1100 B=1010, no backpressure
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req(4'b1100, 4'b1010, 3'(i), 1'b0, 1'b0, SWEEP_Y[i], 1'b0, SWEEP_P[i]);
        end
        tick(); tick();
        check("sweep_drained", 32'(level), 32'd0);

        // Backpressure: three requests against a stalled consumer
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'b0011; in_b = 4'b0101; in_op = 3'b010; in_acc = 1'b0;
        check("bp_ready1", 32'(in_ready), 32'd1);
        sb.push_back({4'b0110, 1'b0, 1'b0});
        tick();
        in_a = 4'b1111; in_b = 4'b1001; in_op = 3'b000;
        check("bp_ready2", 32'(in_ready), 32'd1);
        sb.push_back({4'b1001, 1'b0, 1'b0});
        tick();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_level", 32'(level), 32'd2);
        in_a = 4'b0001; in_b = 4'b0010; in_op = 3'b001;
        tick(); tick();
        check("bp_hold_level", 32'(level), 32'd2);
        check("bp_hold_y", 32'(out_y), 32'(4'b0110));
        out_ready = 1'b1;
        check("bp_no_comb_path", 32'(in_ready), 32'd0);
        tick();
        check("bp_after_pop_ready", 32'(in_ready), 32'd1);
        check("bp_after_pop_level", 32'(level), 32'd1);
        sb.push_back({4'b0011, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        check("bp_push_pop_level", 32'(level), 32'd1);
        tick();
        check("bp_drained", 32'(level), 32'd0);
        check("bp_empty_valid", 32'(out_valid), 32'd0);

        // Accumulate chain
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        req(4'b0110, 4'b0001, 3'b001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1);
        req(4'b0110, 4'b0100, 3'b001, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
        req(4'b0110, 4'b1000, 3'b001, 1'b1, 1'b0, 4'b1101, 1'b0, 1'b1);
        req(4'b0110, 4'b1111, 3'b010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        req(4'b0110, 4'b0000, 3'b111, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);

        // Clear colliding with an accepted accumulate, then a bare clear
        req(4'b0000, 4'b1111, 3'b001, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
        req(4'b0000, 4'b0011, 3'b001, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);
        req(4'b0000, 4'b0000, 3'b111, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        req(4'b1111, 4'b0000, 3'b111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);

        // Zero flag from a plain AND
        req(4'b0101, 4'b1010, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(); tick(); tick();
        check("mid_drained", 32'(level), 32'd0);

        // Reset while full, with a request on the input
        out_ready = 1'b0;
        req(4'b0000, 4'b0110, 3'b001, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
        req(4'b1001, 4'b0000, 3'b111, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0);
        check("pre_reset_level", 32'(level), 32'd2);
        in_valid = 1'b1; in_a = 4'b1011; in_op = 3'b111; in_acc = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("post_reset_level", 32'(level), 32'd0);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_ready", 32'(in_ready), 32'd1);
        check("post_reset_y", 32'(out_y), 32'd0);
        out_ready = 1'b1;
        req(4'b1011, 4'b0000, 3'b111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick(); tick(); tick();
        check("final_level", 32'(level), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
